// File: rtl/wb_burst_master.sv
// Wishbone burst master with a first-word-fall-through write FIFO.
// Takes one command at a time, runs an incrementing burst (cti 010, 111 on the last
// beat), returns read words with one cycle of latency, and pulses done/err at the end.
module wb_burst_master #(
   parameter int unsigned DW  = 32,
   parameter int unsigned AW  = 32,
   parameter int unsigned BLW = 5
) (
   input  logic              sys_clk,
   input  logic              RESETN,
   input  logic              init_done,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [BLW-1:0]    cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DW-1:0]     wdata,
   output logic              rdata_valid,
   output logic [DW-1:0]     rdata,
   output logic              done,
   output logic              err,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [AW-1:0]     wb_addr_o,
   output logic [DW-1:0]     wb_dat_o,
   output logic [DW/8-1:0]   wb_sel_o,
   output logic [2:0]        wb_cti_o,
   input  logic              wb_ack_i,
   input  logic [DW-1:0]     wb_dat_i
);

   localparam int unsigned DEPTH = 2 ** BLW;
   localparam int unsigned BYTES = DW / 8;
   localparam int unsigned SHIFT = $clog2(BYTES);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_DATA = 2'd1;
   localparam logic [1:0] BURST     = 2'd2;
   localparam logic [1:0] DONE      = 2'd3;

   logic [1:0]     state_q, state_d;
   logic           we_q;
   logic [AW-1:0]  addr_q;
   logic [BLW-1:0] len_q;
   logic [BLW-1:0] beat_cnt_q;
   logic           err_q;

   logic [DW-1:0]  mem [DEPTH];
   logic [BLW-1:0] wr_ptr_q, rd_ptr_q;
   logic [BLW:0]   count_q, count_d;

   logic [DW-1:0]  rdata_q;
   logic           rdata_valid_q;

   logic in_burst, accept, full, push, pop, beat_ack, last_beat;

   assign in_burst  = (state_q == BURST);
   assign accept    = cmd_valid & cmd_ready;
   assign full      = (count_q == (BLW+1)'(DEPTH));
   assign push      = wdata_valid & wdata_ready;
   assign beat_ack  = in_burst & wb_ack_i;
   assign pop       = beat_ack & we_q;
   assign last_beat = (beat_cnt_q == (len_q - BLW'(1)));
   assign count_d   = count_q + (BLW+1)'(push) - (BLW+1)'(pop);

   // Next-state logic; WAIT_DATA looks at the post-push level so the burst starts
   // right after the word that satisfies the length is written.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cmd_len == '0)  state_d = DONE;
               else if (cmd_we)    state_d = WAIT_DATA;
               else                state_d = BURST;
            end
         end
         WAIT_DATA: if (count_d >= {1'b0, len_q}) state_d = BURST;
         BURST:     if (wb_ack_i && last_beat)    state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // FSM state and latched command fields.
   always_ff @(posedge sys_clk or negedge RESETN) begin
      if (!RESETN) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q       <= cmd_we;
            addr_q     <= cmd_addr;
            len_q      <= cmd_len;
            beat_cnt_q <= '0;
            err_q      <= (cmd_len == '0);
         end else if (beat_ack) begin
            beat_cnt_q <= beat_cnt_q + BLW'(1);
         end
      end
   end

   // Write FIFO pointers and fill level; pointers wrap naturally at DEPTH.
   always_ff @(posedge sys_clk or negedge RESETN) begin
      if (!RESETN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + BLW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + BLW'(1);
         count_q <= count_d;
      end
   end

   // FIFO storage; contents are don't-care once pointers are reset.
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr_q] <= wdata;
   end

   // Read return path, one cycle after each read ack.
   always_ff @(posedge sys_clk or negedge RESETN) begin
      if (!RESETN) begin
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         rdata_valid_q <= beat_ack & ~we_q;
         if (beat_ack && !we_q) rdata_q <= wb_dat_i;
      end
   end

   // Ready outputs are gated by RESETN so they read low while reset is held.
   assign cmd_ready   = RESETN & init_done & (state_q == IDLE);
   assign wdata_ready = RESETN & ~full;
   assign rdata_valid = rdata_valid_q;
   assign rdata       = rdata_q;
   assign done        = (state_q == DONE);
   assign err         = done & err_q;

   assign wb_cyc_o  = in_burst;
   assign wb_stb_o  = in_burst;
   assign wb_we_o   = in_burst & we_q;
   assign wb_sel_o  = in_burst ? '1 : '0;
   assign wb_cti_o  = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
   assign wb_addr_o = addr_q + (AW'(beat_cnt_q) << SHIFT);
   assign wb_dat_o  = mem[rd_ptr_q];

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with hand-computed expectations.
module tb_wb_burst_master;

   logic        sys_clk = 1'b0;
   logic        RESETN;
   logic        init_done;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_addr;
   logic [4:0]  cmd_len;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [31:0] wdata;
   logic        rdata_valid;
   logic [31:0] rdata;
   logic        done;
   logic        err;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_addr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [2:0]  wb_cti_o;
   logic        wb_ack_i;
   logic [31:0] wb_dat_i;

   int vectors     = 0;
   int miscompares = 0;

   wb_burst_master dut (
      .sys_clk     (sys_clk),
      .RESETN      (RESETN),
      .init_done   (init_done),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_we      (cmd_we),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .wdata       (wdata),
      .rdata_valid (rdata_valid),
      .rdata       (rdata),
      .done        (done),
      .err         (err),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_addr_o   (wb_addr_o),
      .wb_dat_o    (wb_dat_o),
      .wb_sel_o    (wb_sel_o),
      .wb_cti_o    (wb_cti_o),
      .wb_ack_i    (wb_ack_i),
      .wb_dat_i    (wb_dat_i)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      wdata_valid = 1'b1;
      wdata       = w;
      tick();
      wdata_valid = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [4:0] len);
      chk("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = addr;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int cnt;
      int np;
      logic pushed;
      logic [31:0] a;

      RESETN      = 1'b0;
      init_done   = 1'b1;
      cmd_valid   = 1'b0;
      cmd_we      = 1'b0;
      cmd_addr    = '0;
      cmd_len     = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      wb_ack_i    = 1'b0;
      wb_dat_i    = '0;

      // Reset state
      #2;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_wdata_ready", 64'(wdata_ready), 64'd0);
      chk("rst_rdata_valid", 64'(rdata_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
      chk("rst_stb", 64'(wb_stb_o), 64'd0);
      chk("rst_we", 64'(wb_we_o), 64'd0);
      chk("rst_cti", 64'(wb_cti_o), 64'd0);
      chk("rst_addr", 64'(wb_addr_o), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      #20;
      RESETN = 1'b1;
      #1;
      chk("post_rst_wdata_ready", 64'(wdata_ready), 64'd1);
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // Write 4 beats at 0x100, ack every cycle; init_done drops mid-burst
      for (int k = 0; k < 4; k++) push_word(32'h11 * 32'(k + 1));
      issue(1'b1, 32'h100, 5'd4);
      chk("s1_wait_cyc", 64'(wb_cyc_o), 64'd0);
      wb_ack_i = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("s1_cyc", 64'(wb_cyc_o), 64'd1);
         chk("s1_we", 64'(wb_we_o), 64'd1);
         chk("s1_sel", 64'(wb_sel_o), 64'hF);
         chk("s1_addr", 64'(wb_addr_o), 64'(32'h100 + 32'(4 * i)));
         chk("s1_cti", 64'(wb_cti_o), (i == 3) ? 64'd7 : 64'd2);
         chk("s1_dat", 64'(wb_dat_o), 64'(32'h11 * 32'(i + 1)));
         if (i == 1) init_done = 1'b0;
         tick();
      end
      chk("s1_done", 64'(done), 64'd1);
      chk("s1_err", 64'(err), 64'd0);
      chk("s1_done_cyc", 64'(wb_cyc_o), 64'd0);
      tick();
      chk("s1_idle_done", 64'(done), 64'd0);
      chk("s1_initlow_ready", 64'(cmd_ready), 64'd0);
      init_done = 1'b1;
      #1;
      chk("s1_inithigh_ready", 64'(cmd_ready), 64'd1);

      // Read 3 beats at 0x200 with two wait states per beat
      wb_ack_i = 1'b0;
      issue(1'b0, 32'h200, 5'd3);
      for (int b = 0; b < 3; b++) begin
         chk("s2_rvalid_w1", 64'(rdata_valid), (b > 0) ? 64'd1 : 64'd0);
         if (b > 0) chk("s2_rdata", 64'(rdata), 64'(32'hA0 + 32'(b - 1)));
         chk("s2_cyc", 64'(wb_cyc_o), 64'd1);
         chk("s2_we", 64'(wb_we_o), 64'd0);
         chk("s2_addr_w1", 64'(wb_addr_o), 64'(32'h200 + 32'(4 * b)));
         chk("s2_cti_w1", 64'(wb_cti_o), (b == 2) ? 64'd7 : 64'd2);
         tick();
         chk("s2_rvalid_w2", 64'(rdata_valid), 64'd0);
         chk("s2_addr_w2", 64'(wb_addr_o), 64'(32'h200 + 32'(4 * b)));
         chk("s2_cti_w2", 64'(wb_cti_o), (b == 2) ? 64'd7 : 64'd2);
         tick();
         chk("s2_addr_ack", 64'(wb_addr_o), 64'(32'h200 + 32'(4 * b)));
         chk("s2_stb_ack", 64'(wb_stb_o), 64'd1);
         wb_ack_i = 1'b1;
         wb_dat_i = 32'hA0 + 32'(b);
         tick();
         wb_ack_i = 1'b0;
      end
      chk("s2_done", 64'(done), 64'd1);
      chk("s2_rvalid_last", 64'(rdata_valid), 64'd1);
      chk("s2_rdata_last", 64'(rdata), 64'hA2);
      chk("s2_done_cyc", 64'(wb_cyc_o), 64'd0);
      tick();
      chk("s2_rvalid_off", 64'(rdata_valid), 64'd0);
      chk("s2_done_off", 64'(done), 64'd0);

      // Write len 8 with only 5 words queued
      wb_ack_i = 1'b1;
      for (int k = 0; k < 5; k++) push_word(32'h1000 + 32'(k));
      issue(1'b1, 32'h300, 5'd8);
      chk("s3_wait_cyc0", 64'(wb_cyc_o), 64'd0);
      tick();
      chk("s3_wait_cyc1", 64'(wb_cyc_o), 64'd0);
      for (int k = 5; k < 7; k++) begin
         push_word(32'h1000 + 32'(k));
         chk("s3_wait_cyc_push", 64'(wb_cyc_o), 64'd0);
      end
      push_word(32'h1007);
      chk("s3_start_cyc", 64'(wb_cyc_o), 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk("s3_addr", 64'(wb_addr_o), 64'(32'h300 + 32'(4 * i)));
         chk("s3_dat", 64'(wb_dat_o), 64'(32'h1000 + 32'(i)));
         chk("s3_cti", 64'(wb_cti_o), (i == 7) ? 64'd7 : 64'd2);
         tick();
      end
      chk("s3_done", 64'(done), 64'd1);
      tick();

      // Zero-length command
      issue(1'b1, 32'h0, 5'd0);
      chk("s4_done", 64'(done), 64'd1);
      chk("s4_err", 64'(err), 64'd1);
      chk("s4_cyc", 64'(wb_cyc_o), 64'd0);
      tick();
      chk("s4_done_off", 64'(done), 64'd0);
      chk("s4_err_off", 64'(err), 64'd0);
      chk("s4_cyc_off", 64'(wb_cyc_o), 64'd0);

      // Fill to 32 words, then push while popping a 31-beat burst across the address wrap
      for (int k = 0; k < 32; k++) begin
         chk("s5_fill_ready", 64'(wdata_ready), 64'd1);
         push_word(32'h5000 + 32'(k));
      end
      chk("s5_full_ready", 64'(wdata_ready), 64'd0);
      wdata_valid = 1'b1;
      wdata       = 32'hDEAD;
      tick();
      wdata_valid = 1'b0;
      chk("s5_full_ready2", 64'(wdata_ready), 64'd0);
      issue(1'b1, 32'hFFFF_FFFC, 5'd31);
      chk("s5_wait_cyc", 64'(wb_cyc_o), 64'd0);
      tick();
      cnt = 32;
      np  = 0;
      wdata_valid = 1'b1;
      for (int i = 0; i < 31; i++) begin
         a = 32'hFFFF_FFFC + 32'(4 * i);
         chk("s5_addr", 64'(wb_addr_o), 64'(a));
         chk("s5_dat", 64'(wb_dat_o), 64'(32'h5000 + 32'(i)));
         chk("s5_cti", 64'(wb_cti_o), (i == 30) ? 64'd7 : 64'd2);
         chk("s5_ready", 64'(wdata_ready), (cnt < 32) ? 64'd1 : 64'd0);
         pushed = (cnt < 32);
         wdata  = 32'h6000 + 32'(np);
         tick();
         if (pushed) np++;
         cnt = cnt + (pushed ? 1 : 0) - 1;
      end
      wdata_valid = 1'b0;
      chk("s5_done", 64'(done), 64'd1);
      chk("s5_done_cyc", 64'(wb_cyc_o), 64'd0);
      tick();
      // Drain the leftovers: the last pre-filled word then the words pushed mid-burst
      issue(1'b1, 32'h0, 5'd31);
      tick();
      for (int i = 0; i < 31; i++) begin
         chk("s5_drain_dat", 64'(wb_dat_o),
             (i == 0) ? 64'h501F : 64'(32'h6000 + 32'(i - 1)));
         tick();
      end
      chk("s5_drain_done", 64'(done), 64'd1);
      tick();

      // Reset at beat 2 of a 4-beat write, then a fresh command
      for (int k = 0; k < 4; k++) push_word(32'h7000 + 32'(k));
      issue(1'b1, 32'h400, 5'd4);
      tick();
      chk("s6_b0_addr", 64'(wb_addr_o), 64'h400);
      tick();
      chk("s6_b1_addr", 64'(wb_addr_o), 64'h404);
      tick();
      chk("s6_b2_addr", 64'(wb_addr_o), 64'h408);
      RESETN = 1'b0;
      #1;
      chk("s6_rst_cyc", 64'(wb_cyc_o), 64'd0);
      chk("s6_rst_stb", 64'(wb_stb_o), 64'd0);
      chk("s6_rst_addr", 64'(wb_addr_o), 64'd0);
      chk("s6_rst_cti", 64'(wb_cti_o), 64'd0);
      chk("s6_rst_wready", 64'(wdata_ready), 64'd0);
      chk("s6_rst_cready", 64'(cmd_ready), 64'd0);
      #3;
      RESETN = 1'b1;
      #1;
      chk("s6_post_wready", 64'(wdata_ready), 64'd1);
      chk("s6_post_cready", 64'(cmd_ready), 64'd1);
      push_word(32'h8000);
      push_word(32'h8001);
      issue(1'b1, 32'h500, 5'd2);
      tick();
      chk("s6_new_addr0", 64'(wb_addr_o), 64'h500);
      chk("s6_new_dat0", 64'(wb_dat_o), 64'h8000);
      chk("s6_new_cti0", 64'(wb_cti_o), 64'd2);
      tick();
      chk("s6_new_addr1", 64'(wb_addr_o), 64'h504);
      chk("s6_new_dat1", 64'(wb_dat_o), 64'h8001);
      chk("s6_new_cti1", 64'(wb_cti_o), 64'd7);
      tick();
      chk("s6_new_done", 64'(done), 64'd1);
      wb_ack_i = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
